uart_tx_feeder: RTL and testbench

- Byte FIFO plus send sequencer sitting directly upstream of the uart transmitter.
- Accepts bytes from a producer (CPU/bridge/pattern generator) in bursts and drains them into the uart's tx_data/tx_send interface.
- Issues exactly one tx_send pulse per byte and never while tx_busy is high, so back-to-back producer writes cannot overrun the serializer.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_feeder_if.sv | 27 ++
 rtl/sync_fifo_byte.sv | 68 ++++++
 rtl/uart_tx_feeder.sv | 115 +++++++++++
 tb/tb_uart_tx_feeder.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared constants and types for the uart tx feeder: sequencer state encoding,
// byte width, default timeouts and a small saturating-increment helper.
package uart_pkg;

    localparam int UART_DATA_W      = 8;
    localparam int DEPTH_LOG2_DEF   = 4;
    localparam int BUSY_TIMEOUT_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BUSY = 2'd1,
        ST_WAIT_DONE = 2'd2
    } tx_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] val);
        return (val == 8'hFF) ? val : val + 8'd1;
    endfunction

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Producer-side write port, FIFO status and uart-side send port of the feeder.
// Handshake: a byte is taken on every clock edge where wr_en is high and full is
// low; tx_send is a one-cycle strobe qualifying tx_data, never issued while
// tx_busy is sampled high.
interface uart_tx_feeder_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic [7:0]          wr_data;
    logic                wr_en;
    logic                full;
    logic                empty;
    logic [DEPTH_LOG2:0] level;
    logic [7:0]          tx_data;
    logic                tx_send;
    logic                tx_busy;
    logic [1:0]          dbg_state;

    modport slave (
        input  wr_data, wr_en, tx_busy,
        output full, empty, level, tx_data, tx_send, dbg_state
    );

    modport master (
        output wr_data, wr_en, tx_busy,
        input  full, empty, level, tx_data, tx_send, dbg_state
    );
endinterface

// File: rtl/sync_fifo_byte.sv
// Circular byte buffer with wrapping read/write pointers and a separate
// occupancy counter; full/empty come straight from the registered level.
module sync_fifo_byte
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [UART_DATA_W-1:0] din,
    output logic [UART_DATA_W-1:0] dout,
    output logic                   full,
    output logic                   empty,
    output logic [DEPTH_LOG2:0]    level
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = 1;
    localparam logic [DEPTH_LOG2:0]   LVL_ONE   = 1;
    localparam logic [DEPTH_LOG2:0]   LVL_DEPTH = DEPTH;

    logic [UART_DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]    level_q, level_d;
    logic                   push_ok;
    logic                   pop_ok;

    // full is judged on the registered level, so a same-cycle pop never rescues a write
    assign full    = (level_q == LVL_DEPTH);
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is deliberately left out of reset; stale bytes are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus send sequencer feeding a uart transmitter one tx_send per byte.
// Optional: define UART_TX_FEEDER_DROP_CNT_EN to add a saturating drop_cnt output.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2   = DEPTH_LOG2_DEF,
    parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_feeder_if.slave   bus
`ifdef UART_TX_FEEDER_DROP_CNT_EN
    ,
    output logic [7:0]        drop_cnt
`endif
);
    localparam int CNT_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;

    tx_state_e              state_q, state_d;
    logic [UART_DATA_W-1:0] tx_data_q, tx_data_d;
    logic                   tx_send_q, tx_send_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [UART_DATA_W-1:0] fifo_dout;

    sync_fifo_byte #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.wr_en),
        .pop   (fifo_pop),
        .din   (bus.wr_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (bus.level)
    );

    assign bus.full      = fifo_full;
    assign bus.empty     = fifo_empty;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_send   = tx_send_q;
    assign bus.dbg_state = state_q;

    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        tx_send_d = 1'b0;
        cnt_d     = cnt_q;
        fifo_pop  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && !bus.tx_busy) begin
                    tx_data_d = fifo_dout;
                    tx_send_d = 1'b1;
                    cnt_d     = '0;
                    fifo_pop  = 1'b1;
                    state_d   = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                // The strobe cycle itself is not counted: the uart cannot react before it has seen tx_send.
                if (bus.tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (tx_send_q) begin
                    cnt_d = cnt_q;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.tx_busy) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            tx_data_q <= '0;
            tx_send_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            tx_send_q <= tx_send_d;
            cnt_q     <= cnt_d;
        end
    end

`ifdef UART_TX_FEEDER_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (bus.wr_en && fifo_full) drop_cnt_d = sat_inc8(drop_cnt_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) drop_cnt_q <= '0;
        else     drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder: reset, single byte, busy burst, overflow,
// busy timeout spacing, pointer wrap-around and reset during a frame.
module tb_uart_tx_feeder;
    import uart_pkg::*;

    logic clk;
    logic rst;
`ifdef UART_TX_FEEDER_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    uart_tx_feeder_if #(.DEPTH_LOG2(4)) bus ();

    uart_tx_feeder #(
        .DEPTH_LOG2   (4),
        .BUSY_TIMEOUT (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus)
`ifdef UART_TX_FEEDER_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int         cmp_cnt = 0;
    int         err_cnt = 0;
    int         cyc = 0;
    int         sent_while_busy = 0;
    bit         auto_busy = 1'b0;
    int         busy_left = 0;
    logic [7:0] got_q[$];
    int         got_cyc_q[$];
    logic [7:0] exp_q[$];

    // One clock: advance, sample the uart side, then run the optional busy model.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.tx_send === 1'b1) begin
            got_q.push_back(bus.tx_data);
            got_cyc_q.push_back(cyc);
            if (bus.tx_busy) sent_while_busy++;
            if (auto_busy) begin
                bus.tx_busy = 1'b1;
                busy_left   = 2;
            end
        end else if (auto_busy) begin
            if (busy_left > 0) busy_left--;
            if (busy_left == 0) bus.tx_busy = 1'b0;
        end
    endtask

    task automatic clear_obs();
        got_q.delete();
        got_cyc_q.delete();
        exp_q.delete();
        sent_while_busy = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        bus.wr_en = 1'b0;
        bus.wr_data = 8'h00;
        bus.tx_busy = 1'b0;
        step();
        step();
        cmp_cnt++;
        if (bus.level !== 5'd0) begin err_cnt++; $display("FAIL reset_level: got %0d want 0", bus.level); end
        cmp_cnt++;
        if (bus.empty !== 1'b1) begin err_cnt++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
        cmp_cnt++;
        if (bus.full !== 1'b0) begin err_cnt++; $display("FAIL reset_full: got %b want 0", bus.full); end
        cmp_cnt++;
        if (bus.tx_send !== 1'b0) begin err_cnt++; $display("FAIL reset_tx_send: got %b want 0", bus.tx_send); end
        cmp_cnt++;
        if (bus.tx_data !== 8'h00) begin err_cnt++; $display("FAIL reset_tx_data: got %h want 00", bus.tx_data); end
        cmp_cnt++;
        if (bus.dbg_state !== ST_IDLE) begin err_cnt++; $display("FAIL reset_state: got %0d want 0", bus.dbg_state); end
`ifdef UART_TX_FEEDER_DROP_CNT_EN
        cmp_cnt++;
        if (drop_cnt !== 8'd0) begin err_cnt++; $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); end
`endif
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_byte();
        clear_obs();
        auto_busy = 1'b0;
        bus.tx_busy = 1'b0;
        bus.wr_en = 1'b1;
        bus.wr_data = 8'hA5;
        step();
        bus.wr_en = 1'b0;
        cmp_cnt++;
        if (bus.empty !== 1'b0 || bus.level !== 5'd1) begin
            err_cnt++; $display("FAIL single_after_write: got empty=%b level=%0d want empty=0 level=1", bus.empty, bus.level);
        end
        cmp_cnt++;
        if (bus.tx_send !== 1'b0) begin err_cnt++; $display("FAIL single_early_send: got %b want 0", bus.tx_send); end
        step();
        cmp_cnt++;
        if (bus.tx_send !== 1'b1 || bus.tx_data !== 8'hA5) begin
            err_cnt++; $display("FAIL single_send: got send=%b data=%h want send=1 data=a5", bus.tx_send, bus.tx_data);
        end
        cmp_cnt++;
        if (bus.empty !== 1'b1) begin err_cnt++; $display("FAIL single_empty_after: got %b want 1", bus.empty); end
        step();
        cmp_cnt++;
        if (bus.tx_send !== 1'b0 || bus.tx_data !== 8'hA5) begin
            err_cnt++; $display("FAIL single_pulse_width: got send=%b data=%h want send=0 data=a5", bus.tx_send, bus.tx_data);
        end
        for (int i = 0; i < 8; i++) step();
        cmp_cnt++;
        if (got_q.size() != 1) begin err_cnt++; $display("FAIL single_count: got %0d want 1", got_q.size()); end
    endtask

    task automatic test_back_to_back_busy();
        int peak;
        clear_obs();
        peak = 0;
        bus.tx_busy = 1'b0;
        busy_left = 0;
        auto_busy = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            bus.wr_en = 1'b1;
            bus.wr_data = 8'(i);
            step();
            if (int'(bus.level) > peak) peak = int'(bus.level);
        end
        bus.wr_en = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (int'(bus.level) > peak) peak = int'(bus.level);
        end
        auto_busy = 1'b0;
        bus.tx_busy = 1'b0;
        cmp_cnt++;
        if (got_q.size() != 5) begin err_cnt++; $display("FAIL burst_count: got %0d want 5", got_q.size()); end
        for (int i = 0; i < 5; i++) begin
            cmp_cnt++;
            if (got_q.size() <= i || got_q[i] !== 8'(i + 1)) begin
                err_cnt++; $display("FAIL burst_byte%0d: got %h want %h", i, (got_q.size() > i) ? got_q[i] : 8'hxx, 8'(i + 1));
            end
        end
        cmp_cnt++;
        if (sent_while_busy != 0) begin err_cnt++; $display("FAIL burst_send_while_busy: got %0d want 0", sent_while_busy); end
        cmp_cnt++;
        if (peak != 4 && peak != 5) begin err_cnt++; $display("FAIL burst_peak_level: got %0d want 4 or 5", peak); end
        cmp_cnt++;
        if (bus.level !== 5'd0) begin err_cnt++; $display("FAIL burst_final_level: got %0d want 0", bus.level); end
    endtask

    task automatic test_overflow();
        clear_obs();
        auto_busy = 1'b0;
        bus.tx_busy = 1'b1;
        for (int i = 0; i < 17; i++) begin
            bus.wr_en = 1'b1;
            bus.wr_data = 8'h10 + 8'(i);
            step();
            if (i == 15) begin
                cmp_cnt++;
                if (bus.full !== 1'b1 || bus.level !== 5'd16) begin
                    err_cnt++; $display("FAIL ovf_full_at_16: got full=%b level=%0d want full=1 level=16", bus.full, bus.level);
                end
            end
        end
        bus.wr_en = 1'b0;
        step();
        cmp_cnt++;
        if (bus.full !== 1'b1 || bus.level !== 5'd16) begin
            err_cnt++; $display("FAIL ovf_after_drop: got full=%b level=%0d want full=1 level=16", bus.full, bus.level);
        end
        cmp_cnt++;
        if (got_q.size() != 0) begin err_cnt++; $display("FAIL ovf_send_while_busy: got %0d sends want 0", got_q.size()); end
`ifdef UART_TX_FEEDER_DROP_CNT_EN
        cmp_cnt++;
        if (drop_cnt !== 8'd1) begin err_cnt++; $display("FAIL ovf_drop_cnt: got %0d want 1", drop_cnt); end
`endif
        bus.tx_busy = 1'b0;
        busy_left = 0;
        auto_busy = 1'b1;
        for (int i = 0; i < 90; i++) step();
        auto_busy = 1'b0;
        bus.tx_busy = 1'b0;
        cmp_cnt++;
        if (got_q.size() != 16) begin err_cnt++; $display("FAIL ovf_drain_count: got %0d want 16", got_q.size()); end
        for (int i = 0; i < 16; i++) begin
            cmp_cnt++;
            if (got_q.size() <= i || got_q[i] !== 8'h10 + 8'(i)) begin
                err_cnt++; $display("FAIL ovf_byte%0d: got %h want %h", i, (got_q.size() > i) ? got_q[i] : 8'hxx, 8'h10 + 8'(i));
            end
        end
        cmp_cnt++;
        if (bus.empty !== 1'b1 || bus.level !== 5'd0) begin
            err_cnt++; $display("FAIL ovf_final: got empty=%b level=%0d want empty=1 level=0", bus.empty, bus.level);
        end
    endtask

    task automatic test_busy_timeout();
        clear_obs();
        auto_busy = 1'b0;
        bus.tx_busy = 1'b0;
        bus.wr_en = 1'b1;
        bus.wr_data = 8'h3C;
        step();
        bus.wr_data = 8'hC3;
        step();
        bus.wr_en = 1'b0;
        for (int i = 0; i < 16; i++) step();
        cmp_cnt++;
        if (got_q.size() != 2) begin
            err_cnt++; $display("FAIL timeout_count: got %0d want 2", got_q.size());
        end else begin
            cmp_cnt++;
            if (got_q[0] !== 8'h3C || got_q[1] !== 8'hC3) begin
                err_cnt++; $display("FAIL timeout_bytes: got %h %h want 3c c3", got_q[0], got_q[1]);
            end
            cmp_cnt++;
            if (got_cyc_q[1] - got_cyc_q[0] != 6) begin
                err_cnt++; $display("FAIL timeout_gap: got %0d want 6", got_cyc_q[1] - got_cyc_q[0]);
            end
        end
    endtask

    task automatic test_wrap_around();
        int n_wr;
        int budget;
        clear_obs();
        n_wr = 0;
        budget = 0;
        bus.tx_busy = 1'b0;
        busy_left = 0;
        auto_busy = 1'b1;
        while ((n_wr < 40 || got_q.size() < 40) && budget < 2000) begin
            if (n_wr < 40 && !bus.full && $urandom_range(0, 3) != 0) begin
                bus.wr_en = 1'b1;
                bus.wr_data = 8'($urandom_range(0, 255));
                exp_q.push_back(bus.wr_data);
                n_wr++;
            end else begin
                bus.wr_en = 1'b0;
            end
            step();
            budget++;
        end
        bus.wr_en = 1'b0;
        for (int i = 0; i < 8; i++) step();
        auto_busy = 1'b0;
        bus.tx_busy = 1'b0;
        cmp_cnt++;
        if (got_q.size() != 40 || budget >= 2000) begin
            err_cnt++; $display("FAIL wrap_count: got %0d want 40 (cycles used %0d)", got_q.size(), budget);
        end
        for (int i = 0; i < 40; i++) begin
            if (got_q.size() > i) begin
                cmp_cnt++;
                if (got_q[i] !== exp_q[i]) begin
                    err_cnt++; $display("FAIL wrap_byte%0d: got %h want %h", i, got_q[i], exp_q[i]);
                end
            end
        end
        cmp_cnt++;
        if (bus.level !== 5'd0) begin err_cnt++; $display("FAIL wrap_final_level: got %0d want 0", bus.level); end
    endtask

    task automatic test_reset_mid_frame();
        int waited;
        clear_obs();
        bus.tx_busy = 1'b0;
        busy_left = 0;
        auto_busy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.wr_en = 1'b1;
            bus.wr_data = 8'h60 + 8'(i);
            step();
        end
        bus.wr_en = 1'b0;
        waited = 0;
        while (bus.dbg_state !== ST_WAIT_DONE && waited < 20) begin
            step();
            waited++;
        end
        cmp_cnt++;
        if (bus.dbg_state !== ST_WAIT_DONE) begin
            err_cnt++; $display("FAIL rstmid_reach_wait_done: got state %0d want 2", bus.dbg_state);
        end
        #2;
        rst = 1'b1;
        #1;
        cmp_cnt++;
        if (bus.level !== 5'd0 || bus.empty !== 1'b1) begin
            err_cnt++; $display("FAIL rstmid_fifo: got level=%0d empty=%b want level=0 empty=1", bus.level, bus.empty);
        end
        cmp_cnt++;
        if (bus.tx_send !== 1'b0 || bus.tx_data !== 8'h00) begin
            err_cnt++; $display("FAIL rstmid_tx: got send=%b data=%h want send=0 data=00", bus.tx_send, bus.tx_data);
        end
        auto_busy = 1'b0;
        bus.tx_busy = 1'b0;
        step();
        rst = 1'b0;
        got_q.delete();
        got_cyc_q.delete();
        for (int i = 0; i < 12; i++) step();
        cmp_cnt++;
        if (got_q.size() != 0 || bus.level !== 5'd0) begin
            err_cnt++; $display("FAIL rstmid_quiet: got sends=%0d level=%0d want sends=0 level=0", got_q.size(), bus.level);
        end
        bus.wr_en = 1'b1;
        bus.wr_data = 8'h5A;
        step();
        bus.wr_en = 1'b0;
        for (int i = 0; i < 10; i++) step();
        cmp_cnt++;
        if (got_q.size() != 1 || got_q[0] !== 8'h5A) begin
            err_cnt++; $display("FAIL rstmid_new_write: got sends=%0d first=%h want 1 x 5a", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        rst = 1'b1;
        bus.wr_en = 1'b0;
        bus.wr_data = 8'h00;
        bus.tx_busy = 1'b0;
        test_reset();
        test_single_byte();
        test_back_to_back_busy();
        test_overflow();
        test_busy_timeout();
        test_wrap_around();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
